// File: rtl/aes_addroundkey_wddl_lanes.sv
// aes_addroundkey_wddl_lanes
// Sequenced WDDL AddRoundKey stage. A dual-rail operand (plaintext or
// next-round state) is XORed with a dual-rail round key one LANE_W-bit lane
// at a time. Each lane gets a PRE cycle with the XOR inputs forced to 0/0,
// then an EVAL cycle, so every rail makes at most one 0->1 transition per
// evaluation. Lane 0 holds the LSBs.
// Optional feature: define WDDL_FAULT_DET_EN to check the captured rails for
// equal-rail (00/11) pairs and raise a sticky fault flag. Without the macro
// fault is tied low and the check logic is absent.
module aes_addroundkey_wddl_lanes #(
    parameter int DW     = 128,
    parameter int LANE_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ld,
    input  logic [DW-1:0] text_in,
    input  logic [DW-1:0] text_in_n,
    input  logic [DW-1:0] sa_next,
    input  logic [DW-1:0] sa_next_n,
    input  logic [DW-1:0] key,
    input  logic [DW-1:0] key_n,
    output logic [DW-1:0] sa,
    output logic [DW-1:0] sa_n,
    output logic          busy,
    output logic          done,
    output logic          fault
);

    localparam int NL  = DW / LANE_W;
    localparam int LCW = (NL > 1) ? $clog2(NL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_r, state_s;

    logic [LCW-1:0]    lc_r;
    logic [DW-1:0]     op_r, op_n_r, key_r, key_n_r;
    logic [DW-1:0]     sa_r, sa_n_r;
    logic              busy_r, done_r;
    logic              capture_s, eval_s, last_lane_s;
    logic [NL-1:0]     lane_sel_s;
    logic [LANE_W-1:0] lane_a_s, lane_a_n_s, lane_b_s, lane_b_n_s;
    logic [LANE_W-1:0] lane_sa_s, lane_sa_n_s;

    assign capture_s   = (state_r == IDLE) && start;
    assign eval_s      = (state_r == EVAL);
    assign last_lane_s = (lc_r == LCW'(NL - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: one PRE/EVAL pair per lane, then a single DONE cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = PRE;
                end else begin
                    state_s = IDLE;
                end
            end
            PRE: begin
                state_s = EVAL;
            end
            EVAL: begin
                if (last_lane_s) begin
                    state_s = DONE;
                end else begin
                    state_s = PRE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Lane gating: only the lane under evaluation reaches the XOR network,
    // every other input (and all inputs during PRE) reads 0 on both rails
    always_comb begin
        lane_a_s   = {LANE_W{1'b0}};
        lane_a_n_s = {LANE_W{1'b0}};
        lane_b_s   = {LANE_W{1'b0}};
        lane_b_n_s = {LANE_W{1'b0}};
        for (int l = 0; l < NL; l++) begin
            lane_sel_s[l] = eval_s && (lc_r == LCW'(l));
            lane_a_s   = lane_a_s   | (lane_sel_s[l] ? op_r   [l*LANE_W +: LANE_W] : {LANE_W{1'b0}});
            lane_a_n_s = lane_a_n_s | (lane_sel_s[l] ? op_n_r [l*LANE_W +: LANE_W] : {LANE_W{1'b0}});
            lane_b_s   = lane_b_s   | (lane_sel_s[l] ? key_r  [l*LANE_W +: LANE_W] : {LANE_W{1'b0}});
            lane_b_n_s = lane_b_n_s | (lane_sel_s[l] ? key_n_r[l*LANE_W +: LANE_W] : {LANE_W{1'b0}});
        end
    end

    // WDDL XOR: positive-logic AND/OR only, so precharged 0/0 inputs give 0/0
    always_comb begin
        lane_sa_s   = (lane_a_s & lane_b_n_s) | (lane_a_n_s & lane_b_s);
        lane_sa_n_s = (lane_a_s & lane_b_s)   | (lane_a_n_s & lane_b_n_s);
    end

    // Operand/key staging and result lanes; result precharged at capture
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= {DW{1'b0}};
            op_n_r  <= {DW{1'b0}};
            key_r   <= {DW{1'b0}};
            key_n_r <= {DW{1'b0}};
            sa_r    <= {DW{1'b0}};
            sa_n_r  <= {DW{1'b0}};
        end else if (capture_s) begin
            op_r    <= ld ? text_in   : sa_next;
            op_n_r  <= ld ? text_in_n : sa_next_n;
            key_r   <= key;
            key_n_r <= key_n;
            sa_r    <= {DW{1'b0}};
            sa_n_r  <= {DW{1'b0}};
        end else begin
            for (int l = 0; l < NL; l++) begin
                if (lane_sel_s[l]) begin
                    sa_r  [l*LANE_W +: LANE_W] <= lane_sa_s;
                    sa_n_r[l*LANE_W +: LANE_W] <= lane_sa_n_s;
                end
            end
        end
    end

    // Lane counter and busy/done handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            lc_r   <= {LCW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= eval_s && last_lane_s;
            if (capture_s) begin
                lc_r   <= {LCW{1'b0}};
                busy_r <= 1'b1;
            end else if (eval_s && last_lane_s) begin
                busy_r <= 1'b0;
            end else if (eval_s) begin
                lc_r   <= lc_r + LCW'(1);
            end
        end
    end

    assign sa   = sa_r;
    assign sa_n = sa_n_r;
    assign busy = busy_r;
    assign done = done_r;

`ifdef WDDL_FAULT_DET_EN
    // Returns 1 when any true/complement pair has equal rails (00 or 11)
    function automatic logic rail_violation(input logic [DW-1:0] t, input logic [DW-1:0] c);
        return |(~(t ^ c));
    endfunction

    logic fault_r;

    // Sticky fault: cleared on accepted start, set from the staged rails one
    // cycle after capture
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (capture_s) begin
            fault_r <= 1'b0;
        end else if (state_r == PRE) begin
            fault_r <= fault_r | rail_violation(op_r, op_n_r) | rail_violation(key_r, key_n_r);
        end
    end

    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_aes_addroundkey_wddl_lanes.sv
// Directed testbench for aes_addroundkey_wddl_lanes (defaults DW=128, LANE_W=32).
// Outputs are sampled on the falling edge; "cycle n" is the half period after
// rising edge E(n), where E0 is the edge that samples start.
module tb_aes_addroundkey_wddl_lanes;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ld;
    logic [127:0] text_in, text_in_n, sa_next, sa_next_n, key, key_n;
    logic [127:0] sa, sa_n;
    logic         busy, done, fault;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_SA  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] LD0_SN   = 128'hffffffff00000000ffffffff00000000;
    localparam logic [127:0] LD0_KEY  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] LD0_SA   = 128'hfedcba9889abcdef0123456776543210;
    localparam logic [127:0] LANE0_SA = 128'h000000000000000000000000c0d0e0f0;
    localparam logic [127:0] LANE0_SN = 128'h0000000000000000000000003f2f1f0f;
`ifdef WDDL_FAULT_DET_EN
    localparam logic FAULT_EXP = 1'b1;
`else
    localparam logic FAULT_EXP = 1'b0;
`endif

    aes_addroundkey_wddl_lanes dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ld        (ld),
        .text_in   (text_in),
        .text_in_n (text_in_n),
        .sa_next   (sa_next),
        .sa_next_n (sa_next_n),
        .key       (key),
        .key_n     (key_n),
        .sa        (sa),
        .sa_n      (sa_n),
        .busy      (busy),
        .done      (done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle start pulse; returns at cycle 0
    task automatic issue();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_fips();
        ld        = 1'b1;
        text_in   = FIPS_PT;
        text_in_n = ~FIPS_PT;
        key       = FIPS_KEY;
        key_n     = ~FIPS_KEY;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ld = 1'b0;
        text_in = '0; text_in_n = '0; sa_next = '0; sa_next_n = '0;
        key = '0; key_n = '0;

        // Reset
        tick(2);
        check_val("rst_sa",    sa,    128'h0);
        check_val("rst_sa_n",  sa_n,  128'h0);
        check_val("rst_busy",  busy,  128'h0);
        check_val("rst_done",  done,  128'h0);
        check_val("rst_fault", fault, 128'h0);
        rst = 1'b0;

        // FIPS-197 round 0, ld=1; inputs scrambled after capture
        load_fips();
        issue();
        check_val("fips_c0_busy", busy, 128'h1);
        check_val("fips_c0_done", done, 128'h0);
        check_val("fips_c0_sa",   sa,   128'h0);
        text_in   = 128'hdeadbeefcafef00d0123456789abcdef;
        text_in_n = ~128'hdeadbeefcafef00d0123456789abcdef;
        key       = 128'h55555555aaaaaaaa55555555aaaaaaaa;
        key_n     = ~128'h55555555aaaaaaaa55555555aaaaaaaa;
        tick(1);
        check_val("fips_c1_sa",   sa,   128'h0);
        check_val("fips_c1_sa_n", sa_n, 128'h0);
        tick(1);
        check_val("fips_c2_sa",   sa,   LANE0_SA);
        check_val("fips_c2_sa_n", sa_n, LANE0_SN);
        tick(5);
        check_val("fips_c7_done", done, 128'h0);
        check_val("fips_c7_busy", busy, 128'h1);
        tick(1);
        check_val("fips_c8_done", done, 128'h1);
        check_val("fips_c8_busy", busy, 128'h0);
        check_val("fips_c8_sa",   sa,   FIPS_SA);
        check_val("fips_c8_sa_n", sa_n, ~FIPS_SA);
        tick(1);
        check_val("fips_c9_done", done, 128'h0);
        check_val("fips_c9_sa",   sa,   FIPS_SA);

        // ld=0 selects sa_next
        load_fips();
        ld        = 1'b0;
        sa_next   = LD0_SN;
        sa_next_n = ~LD0_SN;
        key       = LD0_KEY;
        key_n     = ~LD0_KEY;
        issue();
        tick(8);
        check_val("ld0_done", done, 128'h1);
        check_val("ld0_sa",   sa,   LD0_SA);
        check_val("ld0_sa_n", sa_n, ~LD0_SA);

        // start held high: one done, re-accepted the cycle after done
        load_fips();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n_done = 0;
        for (int c = 0; c < 18; c++) begin
            if (c == 9)  check_val("hold_c9_busy",  busy, 128'h0);
            if (c == 10) check_val("hold_c10_busy", busy, 128'h1);
            n_done += int'(done);
            tick(1);
        end
        check_val("hold_one_done", n_done, 128'h1);
        check_val("hold_c18_done", done,   128'h1);
        check_val("hold_c18_sa",   sa,     FIPS_SA);
        start = 1'b0;
        tick(2);

        // Reset mid-operation
        issue();
        tick(3);
        rst = 1'b1;
        tick(1);
        check_val("mrst_busy", busy, 128'h0);
        check_val("mrst_done", done, 128'h0);
        check_val("mrst_sa",   sa,   128'h0);
        check_val("mrst_sa_n", sa_n, 128'h0);
        rst = 1'b0;
        n_done = 0;
        repeat (10) begin
            n_done += int'(done);
            tick(1);
        end
        check_val("mrst_no_done", n_done, 128'h0);
        issue();
        tick(8);
        check_val("mrst_fresh_done", done, 128'h1);
        check_val("mrst_fresh_sa",   sa,   FIPS_SA);

        // Rail fault on text_in bit 5
        text_in_n = ~FIPS_PT ^ 128'h20;
        issue();
        check_val("flt_c0", fault, 128'h0);
        tick(1);
        check_val("flt_c1", fault, 128'(FAULT_EXP));
        tick(7);
        check_val("flt_c8_done", done,  128'h1);
        check_val("flt_c8",      fault, 128'(FAULT_EXP));
        check_val("flt_c8_sa",   sa,    FIPS_SA);
        tick(2);
        check_val("flt_sticky", fault, 128'(FAULT_EXP));
        text_in_n = ~FIPS_PT;
        issue();
        check_val("flt_clr_c0", fault, 128'h0);
        tick(1);
        check_val("flt_clr_c1", fault, 128'h0);
        tick(7);
        check_val("flt_clr_done", done, 128'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
